// File: rtl/thermo_decoder.sv
`default_nettype none
// thermo_decoder -- two-stage valid/ready decoder from thermometer code to index, with bubble detection
// and a saturating bubble counter. Revision 1.0

module thermo_decoder #(
  parameter  int WIDTH = 16,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_zero,
  output logic            out_err,
  output logic [7:0]      err_cnt,
  input  logic            err_clr
);

  logic [IDXW-1:0] k;
  logic            zero_word;
  logic            legal_word;
  logic            bubble_word;

  logic            s1_valid;
  logic [IDXW-1:0] s1_idx;
  logic            s1_zero;
  logic            s1_err;

  logic            s2_load;
  logic            s1_adv;
  logic            accept;
  logic            consume;

  // Scanning down from the MSB leaves the lowest set bit as the final winner.
  always_comb begin
    k = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_data[i]) k = IDXW'(i);
    end
  end

  assign zero_word   = (in_data == '0);
  assign legal_word  = (in_data == ({WIDTH{1'b1}} << k));
  assign bubble_word = !zero_word && !legal_word;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s2_load || !s1_valid;
  // Gated by rst_n so the block refuses words while held in reset.
  assign in_ready = rst_n && s1_adv;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_zero  <= 1'b0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx  <= k;
        s1_zero <= zero_word;
        s1_err  <= bubble_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_idx  <= s1_idx;
        out_zero <= s1_zero;
        out_err  <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      err_cnt <= 8'd0;
    end else if (consume && out_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_thermo_decoder.sv
`default_nettype none
// tb_thermo_decoder -- directed and random checks of thermo_decoder at WIDTH=8.
// Revision 1.0

module tb_thermo_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_zero;
  logic       out_err;
  logic [7:0] err_cnt;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  thermo_decoder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lowest set bit by upward scan; legal iff the inverted word is 2^k-1.
  function automatic logic [4:0] model(input logic [7:0] d);
    logic [2:0] idx;
    logic       found;
    logic [7:0] inv;
    logic       legal;
    logic       zero;
    idx = 3'd0;
    found = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (!found && d[j]) begin
        idx = 3'(j);
        found = 1'b1;
      end
    end
    inv   = ~d;
    legal = ((inv & (inv + 8'd1)) == 8'd0);
    zero  = (d == 8'd0);
    return {idx, zero, !zero && !legal};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; err_clr = 1'b0;
    #3;
    checks++;
    if ({out_valid, out_idx, out_zero, out_err, err_cnt, in_ready} !== 15'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%0b idx=%0d z=%0b e=%0b cnt=%0d rdy=%0b, expected all 0",
               out_valid, out_idx, out_zero, out_err, err_cnt, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_legal_sweep();
    @(posedge clk); #1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hF8;
    @(posedge clk); #1; in_data = 8'hFF;
    @(posedge clk); #1; in_data = 8'h80;
    checks++;
    if ({out_valid, out_idx, out_err} !== {1'b1, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL sweep_F8: got v=%0b idx=%0d e=%0b expected v=1 idx=3 e=0", out_valid, out_idx, out_err);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++;
    if ({out_valid, out_idx, out_err} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL sweep_FF: got v=%0b idx=%0d e=%0b expected v=1 idx=0 e=0", out_valid, out_idx, out_err);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_idx, out_err} !== {1'b1, 3'd7, 1'b0}) begin
      errors++;
      $display("FAIL sweep_80: got v=%0b idx=%0d e=%0b expected v=1 idx=7 e=0", out_valid, out_idx, out_err);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_drained: got v=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_zero_bubble();
    @(posedge clk); #1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1; in_data = 8'hB8;
    @(posedge clk); #1; in_valid = 1'b0;
    checks++;
    if ({out_valid, out_zero, out_idx, out_err} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL zero_word: got v=%0b z=%0b idx=%0d e=%0b expected v=1 z=1 idx=0 e=0",
               out_valid, out_zero, out_idx, out_err);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_zero, out_idx, out_err} !== {1'b1, 1'b0, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL bubble_word: got v=%0b z=%0b idx=%0d e=%0b expected v=1 z=0 idx=3 e=1",
               out_valid, out_zero, out_idx, out_err);
    end
    @(posedge clk); #1;
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bubble_count: got %0d expected 1", err_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [4];
    logic [2:0] exp_idx [4];
    int sent;
    int rcv;
    words[0] = 8'hF0; words[1] = 8'hE0; words[2] = 8'hC0; words[3] = 8'h80;
    exp_idx[0] = 3'd4; exp_idx[1] = 3'd5; exp_idx[2] = 3'd6; exp_idx[3] = 3'd7;
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; in_data = words[0]; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_w0: got %0b expected 1", in_ready);
    end
    @(posedge clk); #1; in_data = words[1]; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_w1: got %0b expected 1", in_ready);
    end
    @(posedge clk); #1; in_data = words[2]; #1;
    checks++;
    if ({in_ready, out_valid, out_idx} !== {1'b0, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL bp_full: got rdy=%0b v=%0b idx=%0d expected rdy=0 v=1 idx=4", in_ready, out_valid, out_idx);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      checks++;
      if ({in_ready, out_valid, out_idx, out_zero, out_err} !== {1'b0, 1'b1, 3'd4, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_stall_hold: cycle %0d got rdy=%0b v=%0b idx=%0d z=%0b e=%0b expected rdy=0 v=1 idx=4 z=0 e=0",
                 c, in_ready, out_valid, out_idx, out_zero, out_err);
      end
    end
    sent = 2;
    rcv  = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? words[sent] : 8'h00;
      #1;
      checks++;
      if (out_valid) begin
        if (rcv >= 4) begin
          errors++;
          $display("FAIL bp_duplicate: got extra result idx=%0d expected none", out_idx);
        end else if (out_idx !== exp_idx[rcv]) begin
          errors++;
          $display("FAIL bp_order: result %0d got idx=%0d expected %0d", rcv, out_idx, exp_idx[rcv]);
        end
        rcv++;
      end else if (rcv < 4) begin
        errors++;
        $display("FAIL bp_gap: cycle %0d got v=0 expected v=1 (result %0d)", c, rcv);
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcv != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d results expected 4", rcv);
    end
  endtask

  task automatic test_midstream_reset();
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hFC;
    @(posedge clk); #1; in_data = 8'hF8;
    @(posedge clk); #1; in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, err_cnt, in_ready} !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got v=%0b cnt=%0d rdy=%0b expected all 0", out_valid, err_cnt, in_ready);
    end
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got %0b expected 1", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_stale: cycle %0d got v=%0b idx=%0d expected v=0", c, out_valid, out_idx);
      end
    end
    in_valid = 1'b1; in_data = 8'hE0;
    @(posedge clk); #1; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_early: got v=%0b expected 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_idx, out_err} !== {1'b1, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_first: got v=%0b idx=%0d e=%0b expected v=1 idx=5 e=0", out_valid, out_idx, out_err);
    end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1; out_ready = 1'b1; err_clr = 1'b0;
    for (int c = 0; c < 263; c++) begin
      in_valid = (c < 260);
      in_data  = 8'hB8;
      @(posedge clk); #1;
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_255: got %0d expected 255", err_cnt);
    end
    err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL sat_clear: got %0d expected 0", err_cnt);
    end
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sat_reinc: got %0d expected 1", err_cnt);
    end
    in_valid = 1'b1; in_data = 8'hB8;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_err} !== 2'b11) begin
      errors++;
      $display("FAIL clr_setup: got v=%0b e=%0b expected v=1 e=1", out_valid, out_err);
    end
    err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_priority: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_soak();
    logic [4:0] q [$];
    logic [4:0] exp;
    logic [7:0] cnt_model;
    logic [7:0] sh;
    int sel;
    @(posedge clk); #1; err_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    while (out_valid) begin
      @(posedge clk); #1;
    end
    cnt_model = 8'd0;
    for (int c = 0; c < 10004; c++) begin
      if (err_cnt !== cnt_model) begin
        errors++;
        $display("FAIL soak_cnt: cycle %0d got %0d expected %0d", c, err_cnt, cnt_model);
      end
      checks++;
      sel = $urandom_range(0, 3);
      sh  = 8'hFF;
      if (sel == 0)      in_data = 8'h00;
      else if (sel == 3) in_data = 8'($urandom);
      else               in_data = sh << $urandom_range(0, 7);
      in_valid  = (c < 10000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (c < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL soak_extra: got idx=%0d with empty model queue", out_idx);
        end else begin
          exp = q.pop_front();
          if ({out_idx, out_zero, out_err} !== exp) begin
            errors++;
            $display("FAIL soak_result: cycle %0d got idx=%0d z=%0b e=%0b expected idx=%0d z=%0b e=%0b",
                     c, out_idx, out_zero, out_err, exp[4:2], exp[1], exp[0]);
          end
          if (exp[0] && cnt_model != 8'hFF) cnt_model = cnt_model + 8'd1;
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data));
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL soak_lost: got %0d undelivered words expected 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_legal_sweep();
    test_zero_bubble();
    test_backpressure();
    test_midstream_reset();
    test_saturation();
    test_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
